sub_bytes_pipe: RTL and testbench

Parametrised, pipelined AES byte-substitution engine: applies the inverse S-box, or optionally the forward S-box, to LANES bytes per beat under a valid/ready handshake. A per-byte mask leaves selected bytes unsubstituted. It sits between the round-key/ShiftRows datapath and MixColumns in the round pipeline, and replaces per-byte combinational lookups with one registered, back-pressurable stage pair.

---
 rtl/aes_sbox_pkg.sv | 63 ++++++
 rtl/sbox_lane.sv | 38 +++
 rtl/sub_bytes_pipe.sv | 101 ++++++++++
 tb/tb_sub_bytes_pipe.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_sbox_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : aes_sbox_pkg
//  Purpose  : AES byte-substitution constants and lookup helpers. Holds the
//             FIPS-197 forward S-box and inverse S-box tables and the lookup
//             functions used by sbox_lane. The forward table only turns into
//             logic when SBOX_FWD_EN is defined and sbox_lane references it.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package aes_sbox_pkg;

   localparam int AES_BYTE_W = 8;

   localparam logic [7:0] FWD_SBOX [256] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
   };

   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
      8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
      8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
      8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
      8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
      8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
      8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
      8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
      8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
      8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
      8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
      8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
      8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
      8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
      8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
      8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
   };

   function automatic logic [7:0] fwd_sbox_f(input logic [7:0] i_b);
      return FWD_SBOX[i_b];
   endfunction

   function automatic logic [7:0] inv_sbox_f(input logic [7:0] i_b);
      return INV_SBOX[i_b];
   endfunction

endpackage : aes_sbox_pkg
`default_nettype wire

// File: rtl/sbox_lane.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : sbox_lane
//  Purpose  : Combinational substitution of one byte. Masked-off bytes pass
//             through bit-exact. Build option SBOX_FWD_EN adds the forward
//             table and lets i_inv choose it; without it the inverse table is
//             always used and i_inv has no effect on the result.
//  Ports    : i_byte [7:0]  byte to substitute
//             i_inv         1 = inverse S-box, 0 = forward S-box
//             i_mask        1 = substitute, 0 = pass i_byte through
//             o_byte [7:0]  result
//  Revision : 1.0 - initial release
// ============================================================================
module sbox_lane
   import aes_sbox_pkg::*;
(
   input  logic [7:0] i_byte,
   input  logic       i_inv,
   input  logic       i_mask,
   output logic [7:0] o_byte
);

   logic [7:0] w_lut;

`ifdef SBOX_FWD_EN
   assign w_lut = i_inv ? inv_sbox_f(i_byte) : fwd_sbox_f(i_byte);
`else
   // Mode bit is still carried to out_inv by the top; only lookup ignores it.
   logic w_unused_inv;
   assign w_unused_inv = i_inv;
   assign w_lut        = inv_sbox_f(i_byte);
`endif

   assign o_byte = i_mask ? w_lut : i_byte;

endmodule : sbox_lane
`default_nettype wire

// File: rtl/sub_bytes_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : sub_bytes_pipe
//  Purpose  : Two-stage, back-pressurable AES byte substitution of LANES bytes
//             per beat. S1 registers the incoming beat, the sbox_lane array
//             looks it up, S2 registers the result. Build option SBOX_FWD_EN
//             enables the forward table selected per beat by in_inv.
//  Ports    : clk, rst_n                 clock, synchronous active-low reset
//             in_valid/in_ready          input handshake
//             in_data [8*LANES-1:0]      byte i at [8i+7:8i]
//             in_mask [LANES-1:0]        1 = substitute byte i
//             in_inv                     1 = inverse, 0 = forward table
//             out_valid/out_ready        output handshake
//             out_data [8*LANES-1:0]     substituted bytes
//             out_inv                    in_inv of the beat
//  Revision : 1.0 - initial release
// ============================================================================
module sub_bytes_pipe
   import aes_sbox_pkg::*;
#(
   parameter int LANES = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [AES_BYTE_W*LANES-1:0] in_data,
   input  logic [LANES-1:0]            in_mask,
   input  logic                        in_inv,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [AES_BYTE_W*LANES-1:0] out_data,
   output logic                        out_inv
);

   localparam int DW = AES_BYTE_W * LANES;

   logic          r_s1_v;
   logic [DW-1:0] r_s1_data;
   logic [LANES-1:0] r_s1_mask;
   logic          r_s1_inv;
   logic          r_s2_v;
   logic [DW-1:0] r_s2_data;
   logic          r_s2_inv;

   logic [DW-1:0] w_sub_data;
   logic          w_s2_load;
   logic          w_s1_load;

   // S2 frees up whenever it is empty or its beat leaves this cycle; S1 may
   // refill in the same cycle it hands over, so full throughput has no bubble.
   assign w_s2_load = r_s1_v && (!r_s2_v || out_ready);
   assign w_s1_load = in_valid && (!r_s1_v || w_s2_load);
   assign in_ready  = rst_n && (!r_s1_v || !r_s2_v || out_ready);

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      sbox_lane u_lane (
         .i_byte (r_s1_data[gi*AES_BYTE_W +: AES_BYTE_W]),
         .i_inv  (r_s1_inv),
         .i_mask (r_s1_mask[gi]),
         .o_byte (w_sub_data[gi*AES_BYTE_W +: AES_BYTE_W])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1_v    <= 1'b0;
         r_s1_data <= '0;
         r_s1_mask <= '0;
         r_s1_inv  <= 1'b0;
         r_s2_v    <= 1'b0;
         r_s2_data <= '0;
         r_s2_inv  <= 1'b0;
      end else begin
         if (w_s1_load) begin
            r_s1_v    <= 1'b1;
            r_s1_data <= in_data;
            r_s1_mask <= in_mask;
            r_s1_inv  <= in_inv;
         end else if (w_s2_load) begin
            r_s1_v    <= 1'b0;
         end

         // out_data keeps its last value when idle; only the valid drops.
         if (w_s2_load) begin
            r_s2_v    <= 1'b1;
            r_s2_data <= w_sub_data;
            r_s2_inv  <= r_s1_inv;
         end else if (out_ready) begin
            r_s2_v    <= 1'b0;
         end
      end
   end

   assign out_valid = r_s2_v;
   assign out_data  = r_s2_data;
   assign out_inv   = r_s2_inv;

endmodule : sub_bytes_pipe
`default_nettype wire

// File: tb/tb_sub_bytes_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_sub_bytes_pipe
//  Purpose  : Self-checking bench for sub_bytes_pipe (LANES = 16). Expected
//             beats come from an arithmetic GF(2^8) S-box model or from
//             constant vectors and are queued on input transfer, then popped
//             on output transfer. Honours SBOX_FWD_EN for expected values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sub_bytes_pipe;

   localparam int LANES = 16;
   localparam int DW    = 8 * LANES;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [DW-1:0]  in_data;
   logic [LANES-1:0] in_mask;
   logic           in_inv;
   logic           out_valid;
   logic           out_ready;
   logic [DW-1:0]  out_data;
   logic           out_inv;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          inv;
   } exp_t;

   exp_t          sb[$];
   exp_t          mon_e;
   logic [DW-1:0] pend_exp;
   int            n_checks = 0;
   int            n_pass   = 0;
   int            n_in     = 0;
   int            n_out    = 0;
   int            cyc      = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sub_bytes_pipe #(.LANES(LANES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_mask   (in_mask),
      .in_inv    (in_inv),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_inv   (out_inv)
   );

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // ---------------- arithmetic S-box model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] r = 8'h00;
      for (int i = 1; i < 256; i++)
         if (gmul(a, 8'(i)) == 8'h01) r = 8'(i);
      return r;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
      return 8'((x << n) | (x >> (8 - n)));
   endfunction

   function automatic logic [7:0] m_fwd(input logic [7:0] x);
      logic [7:0] b = ginv(x);
      return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] m_inv(input logic [7:0] y);
      return ginv(rotl(y, 1) ^ rotl(y, 3) ^ rotl(y, 6) ^ 8'h05);
   endfunction

   function automatic logic [DW-1:0] model(input logic [DW-1:0] d, input logic [LANES-1:0] m,
                                           input logic inv);
      logic [DW-1:0] r = d;
      logic          use_fwd;
`ifdef SBOX_FWD_EN
      use_fwd = !inv;
`else
      use_fwd = 1'b0;
`endif
      for (int i = 0; i < LANES; i++)
         if (m[i]) r[i*8 +: 8] = use_fwd ? m_fwd(d[i*8 +: 8]) : m_inv(d[i*8 +: 8]);
      return r;
   endfunction

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && out_ready) begin
            n_out++;
            if (sb.size() == 0) begin
               check("spurious_out", DW'(out_valid), DW'(0));
            end else begin
               mon_e = sb.pop_front();
               check("out_data", out_data, mon_e.data);
               check("out_inv", DW'(out_inv), DW'(mon_e.inv));
            end
         end
         if (in_valid && in_ready) begin
            sb.push_back('{data: pend_exp, inv: in_inv});
            n_in++;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_beat_exp(input logic [DW-1:0] d, input logic [LANES-1:0] m,
                                input logic inv, input logic [DW-1:0] e);
      bit acc = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_mask  = m;
      in_inv   = inv;
      pend_exp = e;
      for (int k = 0; k < 50 && !acc; k++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      check("accept", DW'(acc), DW'(1));
   endtask

   task automatic send_beat(input logic [DW-1:0] d, input logic [LANES-1:0] m, input logic inv);
      send_beat_exp(d, m, inv, model(d, m, inv));
   endtask

   task automatic drain();
      for (int k = 0; k < 100 && sb.size() != 0; k++) @(posedge clk);
      #1;
      check("drain_empty", DW'(sb.size()), DW'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] kv;
      int            c0;
      int            in0;
      int            out0;
      bit            done;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_mask   = '0;
      in_inv    = 1'b0;
      out_ready = 1'b1;
      pend_exp  = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", DW'(out_valid), DW'(0));
      check("rst_in_ready", DW'(in_ready), DW'(0));
      check("rst_out_data", out_data, DW'(0));
      check("rst_out_inv", DW'(out_inv), DW'(0));
      rst_n = 1'b1;
      #1;
      check("rdy_after_rst", DW'(in_ready), DW'(1));

      // single beat of zeros, latency of two edges
      send_beat_exp('0, '1, 1'b1, {16{8'h52}});
      in_valid = 1'b0;
      check("lat_edge1", DW'(out_valid), DW'(0));
      @(posedge clk); #1;
      check("lat_edge2", DW'(out_valid), DW'(1));
      drain();

      // known vectors, lane 0 is the low byte
      kv = {{12{8'h00}}, 8'h00, 8'h7c, 8'hff, 8'h63};
      send_beat_exp(kv, '1, 1'b1, {{12{8'h52}}, 8'h52, 8'h01, 8'h7d, 8'h00});
`ifdef SBOX_FWD_EN
      send_beat_exp(kv, '1, 1'b0, {{12{8'h63}}, 8'h63, 8'h10, 8'h16, 8'hfb});
`else
      send_beat_exp(kv, '1, 1'b0, {{12{8'h52}}, 8'h52, 8'h01, 8'h7d, 8'h00});
`endif
      // mask: only lanes 0 and 2 substituted
      send_beat_exp({16{8'h63}}, 16'h0005, 1'b1, {{13{8'h63}}, 8'h00, 8'h63, 8'h00});
      in_valid = 1'b0;
      drain();

      // backpressure: 6 beats, out_ready low for 4 cycles at the start
      in0  = n_in;
      out0 = n_out;
      out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 6; i++)
               send_beat({4{$urandom}}, LANES'($urandom), 1'($urandom));
            in_valid = 1'b0;
         end
         begin
            repeat (4) @(posedge clk);
            #1;
            check("bp_in_ready_low", DW'(in_ready), DW'(0));
            check("bp_accepted", DW'(n_in - in0), DW'(2));
            out_ready = 1'b1;
         end
      join
      drain();
      check("bp_in_count", DW'(n_in - in0), DW'(6));
      check("bp_out_count", DW'(n_out - out0), DW'(6));

      // streaming alternation of modes on 0x52
      c0 = cyc;
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0)
            send_beat_exp({16{8'h52}}, '1, 1'b1, {16{8'h48}});
         else
`ifdef SBOX_FWD_EN
            send_beat_exp({16{8'h52}}, '1, 1'b0, {16{8'h00}});
`else
            send_beat_exp({16{8'h52}}, '1, 1'b0, {16{8'h48}});
`endif
      end
      in_valid = 1'b0;
      check("stream_cycles", DW'(cyc - c0), DW'(8));
      drain();

      // random data, masks, modes with random output stalls
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 24; i++)
               send_beat({$urandom, $urandom, $urandom, $urandom}, LANES'($urandom), 1'($urandom));
            in_valid = 1'b0;
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk); #1;
               out_ready = 1'($urandom_range(0, 1));
            end
            out_ready = 1'b1;
         end
      join
      drain();

      // reset with two beats in flight
      out_ready = 1'b0;
      send_beat({16{8'h11}}, '1, 1'b1);
      send_beat({16{8'h22}}, '1, 1'b0);
      in_valid = 1'b0;
      rst_n = 1'b0;
      sb.delete();
      #1;
      check("mid_rst_in_ready", DW'(in_ready), DW'(0));
      @(posedge clk); #1;
      check("mid_rst_out_valid", DW'(out_valid), DW'(0));
      check("mid_rst_out_data", out_data, DW'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      #1;
      check("post_rst_in_ready", DW'(in_ready), DW'(1));
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         check("no_stale", DW'(out_valid), DW'(0));
      end
      send_beat({16{8'hff}}, '1, 1'b1);
      in_valid = 1'b0;
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_sub_bytes_pipe
`default_nettype wire
